sequenciador_lote: RTL
======================

Name: sequenciador_lote

Overview:
Batch sequencer for the bottling line. It drives conveyor motor, fill valve and sealer through one bottle cycle per position event. It counts accepted bottles into dozens and dozens into batches, tracks cork stock, and raises the alarm on fill timeout or cork starvation. It sits between the debounced sensor/button pulses and the actuator outputs. The display path reads its counters.

Parameters:
GARRAFAS_DUZIA, 12, accepted bottles per dozen
DUZIAS_LOTE, 10, dozens per batch
T_VEDA, 4, sealer pulse width in clock cycles
T_ENCHE_MAX, 200, fill timeout in clock cycles
ESTOQUE_INI, 20, cork stock after reset
REPOR_QTD, 15, corks added per refill pulse

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_pulso  in  1  one-cycle start/stop request
pg  in  1  bottle in position (active-high)
ch  in  1  bottle full (active-high)
cq  in  1  quality OK, sampled in CHECK
repor_pulso  in  1  one-cycle cork refill event
ack_alarme  in  1  one-cycle alarm acknowledge
motor, ev, ve, alarme  out  1 each  conveyor, valve, sealer, alarm
cont_garrafas  out  4  accepted bottles in current dozen (0..11)
cont_duzias  out  7  dozens in current batch (0..DUZIAS_LOTE-1)
estoque  out  7  cork stock (0..99)
rejeitadas  out  7  rejected bottles, saturating at 99
duzia_pulso, lote_pulso  out  1 each  one-cycle completion strobes
estado  out  4  current state code, for debug LEDs

Behaviour:
- Reset sets state IDLE, all actuator outputs and strobes to 0, all counters to 0, estoque=ESTOQUE_INI, stop_pend=0 and the timer to 0.
- Outputs are Moore, decoded from the registered state:
  - motor=1 in MOVE, EXIT and REJECT.
  - ev=1 in FILL.
  - ve=1 in SEAL.
  - alarme=1 in ALARM.
- IDLE: on start_pulso, go to ALARM if estoque==0, otherwise go to EXIT. EXIT clears the old bottle first.
- EXIT and REJECT: wait until pg==0, then go to MOVE.
  - REJECT increments rejeitadas once, on entry, saturating at 99.
- MOVE:
  - On entry, if stop_pend is set, go to IDLE and clear stop_pend.
  - Else, if estoque==0, go to ALARM.
  - Else, pg==1 moves to FILL on the next cycle. Motor drops in the same cycle FILL is entered.
- FILL: the timer counts from 0.
  - ch==1 moves to SEAL.
  - If the timer reaches T_ENCHE_MAX-1 with ch==0, go to ALARM.
  - ch takes priority if both happen in the same cycle.
- SEAL: ve is held for exactly T_VEDA cycles. estoque decrements once, on entry. The state then moves to CHECK.
- CHECK: one cycle.
  - cq==0: go to REJECT.
  - cq==1: cont_garrafas increments.
  - When cont_garrafas reaches GARRAFAS_DUZIA-1 and increments: cont_garrafas wraps to 0, cont_duzias increments, duzia_pulso=1 for one cycle.
  - If that makes cont_duzias reach DUZIAS_LOTE: cont_duzias wraps to 0, lote_pulso=1 in the same cycle as duzia_pulso, next state is DONE. Otherwise the next state is EXIT.
- DONE: actuators off. start_pulso goes to EXIT and starts a new batch; counters are already 0.
- ALARM: actuators off, alarme=1. ack_alarme moves to IDLE only if estoque>0 or the alarm cause was a timeout. Otherwise the state stays in ALARM. A 1-bit cause register records the cause.
- start_pulso in EXIT, MOVE, FILL, SEAL, CHECK or REJECT sets stop_pend. The current bottle completes and the stop takes effect at the next MOVE entry. Counters are held across a stop.
- repor_pulso adds REPOR_QTD to estoque in any state, saturating at 99.
  - If it coincides with the SEAL decrement, the net change is REPOR_QTD-1, then saturation is applied.
- Reset mid-cycle aborts immediately. No partial-count carry is kept.
- All counters are binary. Display conversion is done elsewhere.

Decomposition:
- Shared package:
  - state encoding: IDLE=0, EXIT=1, MOVE=2, FILL=3, SEAL=4, CHECK=5, REJECT=6, ALARM=7, DONE=8
  - saturation limit 99
  - cause codes: CAUSA_TIMEOUT, CAUSA_ROLHA
- One sub-module, estoque_rolhas: saturating up/down cork counter with simultaneous add/decrement. The FSM, timer and count logic stay in sequenciador_lote.

Test Plan:
- Nominal bottle:
  - Stimulus: reset; start_pulso; pg pulse low then high; ch=1 after 5 cycles; cq=1.
  - Response: ev high for 5 cycles, then ve high for exactly 4 cycles; estoque 20→19; cont_garrafas=1; state returns to EXIT.
- Dozen and batch rollover:
  - Stimulus: run 120 accepted bottles.
  - Response: duzia_pulso fires 10 times; lote_pulso fires once, coincident with the 10th duzia_pulso; state DONE; cont_duzias=0, cont_garrafas=0.
- Fill timeout:
  - Stimulus: hold ch=0 in FILL.
  - Response: ALARM at cycle 200 with ev=0 and alarme=1; ack_alarme → IDLE; estoque unchanged.
- Cork starvation:
  - Stimulus: ESTOQUE_INI=1, run 2 bottles.
  - Response: second MOVE entry goes to ALARM. ack_alarme alone keeps ALARM. repor_pulso then ack_alarme → IDLE with estoque=15.
- Reject and saturation:
  - Stimulus: cq=0 on one bottle.
  - Response: rejeitadas=1, cont_garrafas unchanged. With rejeitadas preloaded at 99 via a run of 99 rejects, it stays at 99.
- Stop and simultaneous events:
  - Stimulus: start_pulso during FILL.
  - Response: the bottle completes, then IDLE with counts held.
  - Stimulus: repor_pulso on the SEAL entry cycle with estoque=90.
  - Response: estoque=99 (saturated).

Source files
------------

// File: rtl/sequenciador_lote_pkg.sv
// Shared definitions for the bottling-line batch sequencer:
// state codes, stock saturation limit and alarm cause codes.
package sequenciador_lote_pkg;

  // State codes are also shown on the debug LEDs, so the values are fixed.
  typedef logic [3:0] estado_t;

  localparam estado_t ST_IDLE   = 4'd0;
  localparam estado_t ST_EXIT   = 4'd1;
  localparam estado_t ST_MOVE   = 4'd2;
  localparam estado_t ST_FILL   = 4'd3;
  localparam estado_t ST_SEAL   = 4'd4;
  localparam estado_t ST_CHECK  = 4'd5;
  localparam estado_t ST_REJECT = 4'd6;
  localparam estado_t ST_ALARM  = 4'd7;
  localparam estado_t ST_DONE   = 4'd8;

  // Upper limit of the two-digit counters (cork stock, rejected bottles).
  localparam logic [6:0] SAT_MAX = 7'd99;

  // Why the line stopped in ALARM; decides whether an acknowledge may clear it.
  typedef enum logic {
    CAUSA_TIMEOUT = 1'b0,
    CAUSA_ROLHA   = 1'b1
  } causa_t;

endpackage

// File: rtl/sequenciador_lote_if.sv
// Sensor/button pulses in, actuator commands and counters out.
// master = the side that drives the pulses (panel/bench), slave = sequencer.
interface sequenciador_lote_if;
  import sequenciador_lote_pkg::*;

  logic       start_pulso;
  logic       pg;
  logic       ch;
  logic       cq;
  logic       repor_pulso;
  logic       ack_alarme;

  logic       motor;
  logic       ev;
  logic       ve;
  logic       alarme;
  logic [3:0] cont_garrafas;
  logic [6:0] cont_duzias;
  logic [6:0] estoque;
  logic [6:0] rejeitadas;
  logic       duzia_pulso;
  logic       lote_pulso;
  estado_t    estado;

  modport master (
    output start_pulso, pg, ch, cq, repor_pulso, ack_alarme,
    input  motor, ev, ve, alarme, cont_garrafas, cont_duzias, estoque,
           rejeitadas, duzia_pulso, lote_pulso, estado
  );

  modport slave (
    input  start_pulso, pg, ch, cq, repor_pulso, ack_alarme,
    output motor, ev, ve, alarme, cont_garrafas, cont_duzias, estoque,
           rejeitadas, duzia_pulso, lote_pulso, estado
  );

endinterface

// File: rtl/sequenciador_lote_estoque.sv
// Cork stock counter: a refill and a seal-consumption can land on the same
// edge; the net change is applied first and then clamped to 0..99.
module estoque_rolhas #(
  parameter int INI   = 20,
  parameter int REPOR = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       repor,
  input  logic       dec,
  output logic [6:0] estoque
);
  import sequenciador_lote_pkg::*;

  localparam logic [6:0]        INI_V   = 7'(INI);
  localparam logic signed [8:0] REPOR_S = 9'(REPOR);
  localparam logic signed [8:0] MAX_S   = $signed({2'b00, SAT_MAX});

  // Clamp a signed net stock value into the displayable range.
  function automatic logic [6:0] satura(input logic signed [8:0] v);
    if (v > MAX_S)
      return SAT_MAX;
    else if (v < 9'sd0)
      return 7'd0;
    else
      return v[6:0];
  endfunction

  logic signed [8:0] soma;

  // Net stock after this cycle's refill and/or consumption.
  always_comb begin
    soma = $signed({2'b00, estoque});
    if (repor)
      soma = soma + REPOR_S;
    if (dec)
      soma = soma - 9'sd1;
  end

  // Stock register; only moves when something happens to it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estoque <= INI_V;
    else if (repor || dec)
      estoque <= satura(soma);
  end

endmodule

// File: rtl/sequenciador_lote.sv
// Bottling-line batch sequencer: one bottle cycle per position event,
// Moore actuator outputs, dozen/batch counting, reject count and alarms.
module sequenciador_lote #(
  parameter int GARRAFAS_DUZIA = 12,
  parameter int DUZIAS_LOTE    = 10,
  parameter int T_VEDA         = 4,
  parameter int T_ENCHE_MAX    = 200,
  parameter int ESTOQUE_INI    = 20,
  parameter int REPOR_QTD      = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  sequenciador_lote_if.slave   bus
);
  import sequenciador_lote_pkg::*;

  // Timer is shared by FILL (timeout) and SEAL (pulse width).
  localparam int TMAX = (T_ENCHE_MAX > T_VEDA) ? T_ENCHE_MAX : T_VEDA;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_FIM_ENCHE = TW'(T_ENCHE_MAX - 1);
  localparam logic [TW-1:0] T_FIM_VEDA  = TW'(T_VEDA - 1);
  localparam logic [3:0]    ULT_GARRAFA = 4'(GARRAFAS_DUZIA - 1);
  localparam logic [6:0]    ULT_DUZIA   = 7'(DUZIAS_LOTE - 1);

  estado_t       estado_q;
  estado_t       estado_d;
  causa_t        causa;
  logic          stop_pend;
  logic [TW-1:0] timer;
  logic [3:0]    cont_g;
  logic [6:0]    cont_d;
  logic [6:0]    rej;
  logic          duzia_q;
  logic          lote_q;
  logic [6:0]    estoque;

  logic          entra_seal;
  logic          aceita;
  logic          rejeita;
  logic          fim_duzia;
  logic          fim_lote;
  logic          em_ciclo;

  // Saturating increment for the reject counter.
  function automatic logic [6:0] incr_sat(input logic [6:0] v);
    if (v >= SAT_MAX)
      return SAT_MAX;
    else
      return v + 7'd1;
  endfunction

  // Events decoded from the registered state and this cycle's inputs.
  always_comb begin
    entra_seal = (estado_q == ST_FILL) && bus.ch;
    aceita     = (estado_q == ST_CHECK) && bus.cq;
    rejeita    = (estado_q == ST_CHECK) && !bus.cq;
    fim_duzia  = aceita && (cont_g == ULT_GARRAFA);
    fim_lote   = fim_duzia && (cont_d == ULT_DUZIA);
    em_ciclo   = (estado_q == ST_EXIT)  || (estado_q == ST_MOVE)  ||
                 (estado_q == ST_FILL)  || (estado_q == ST_SEAL)  ||
                 (estado_q == ST_CHECK) || (estado_q == ST_REJECT);
  end

  // Next-state logic for the bottle cycle.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_IDLE: begin
        if (bus.start_pulso)
          estado_d = (estoque == 7'd0) ? ST_ALARM : ST_EXIT;
      end
      ST_EXIT, ST_REJECT: begin
        // Wait for the previous bottle to leave the position sensor.
        if (!bus.pg)
          estado_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (stop_pend)
          estado_d = ST_IDLE;
        else if (estoque == 7'd0)
          estado_d = ST_ALARM;
        else if (bus.pg)
          estado_d = ST_FILL;
      end
      ST_FILL: begin
        // Bottle-full wins over a timeout landing on the same cycle.
        if (bus.ch)
          estado_d = ST_SEAL;
        else if (timer == T_FIM_ENCHE)
          estado_d = ST_ALARM;
      end
      ST_SEAL: begin
        if (timer == T_FIM_VEDA)
          estado_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!bus.cq)
          estado_d = ST_REJECT;
        else if (fim_lote)
          estado_d = ST_DONE;
        else
          estado_d = ST_EXIT;
      end
      ST_DONE: begin
        if (bus.start_pulso)
          estado_d = ST_EXIT;
      end
      ST_ALARM: begin
        // A cork alarm is only cleared once stock has been refilled.
        if (bus.ack_alarme && ((estoque != 7'd0) || (causa == CAUSA_TIMEOUT)))
          estado_d = ST_IDLE;
      end
      default: estado_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estado_q <= ST_IDLE;
    else
      estado_q <= estado_d;
  end

  // Alarm cause is latched on entry: only FILL can time out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      causa <= CAUSA_ROLHA;
    else if ((estado_d == ST_ALARM) && (estado_q != ST_ALARM))
      causa <= (estado_q == ST_FILL) ? CAUSA_TIMEOUT : CAUSA_ROLHA;
  end

  // Stop request mid-cycle is parked until the conveyor next reaches MOVE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stop_pend <= 1'b0;
    else if ((estado_q == ST_MOVE) && stop_pend)
      stop_pend <= 1'b0;
    else if (bus.start_pulso && em_ciclo)
      stop_pend <= 1'b1;
  end

  // Cycle timer restarts on every state change and runs in FILL/SEAL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      timer <= '0;
    else if (estado_d != estado_q)
      timer <= '0;
    else if ((estado_q == ST_FILL) || (estado_q == ST_SEAL))
      timer <= timer + 1'b1;
  end

  // Accepted-bottle and dozen counters with rollover.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont_g <= 4'd0;
      cont_d <= 7'd0;
    end else if (aceita) begin
      if (fim_duzia) begin
        cont_g <= 4'd0;
        cont_d <= fim_lote ? 7'd0 : cont_d + 7'd1;
      end else begin
        cont_g <= cont_g + 4'd1;
      end
    end
  end

  // Completion strobes, aligned with the wrapped counter values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      duzia_q <= 1'b0;
      lote_q  <= 1'b0;
    end else begin
      duzia_q <= fim_duzia;
      lote_q  <= fim_lote;
    end
  end

  // Rejected-bottle counter, bumped once on the way into REJECT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rej <= 7'd0;
    else if (rejeita)
      rej <= incr_sat(rej);
  end

  // One cork is consumed as the sealer engages.
  estoque_rolhas #(
    .INI   (ESTOQUE_INI),
    .REPOR (REPOR_QTD)
  ) u_estoque (
    .clock   (clock),
    .reset   (reset),
    .repor   (bus.repor_pulso),
    .dec     (entra_seal),
    .estoque (estoque)
  );

  assign bus.motor         = (estado_q == ST_MOVE) || (estado_q == ST_EXIT) ||
                             (estado_q == ST_REJECT);
  assign bus.ev            = (estado_q == ST_FILL);
  assign bus.ve            = (estado_q == ST_SEAL);
  assign bus.alarme        = (estado_q == ST_ALARM);
  assign bus.cont_garrafas = cont_g;
  assign bus.cont_duzias   = cont_d;
  assign bus.estoque       = estoque;
  assign bus.rejeitadas    = rej;
  assign bus.duzia_pulso   = duzia_q;
  assign bus.lote_pulso    = lote_q;
  assign bus.estado        = estado_q;

endmodule
